param_bus_arbiter: RTL and testbench

//  Shares the synth parameter bus (7-bit address, 8-bit data, env/osc/m1/m2/com selects, write/read strobes)

---
 rtl/param_bus_arbiter_pkg.sv | 35 +++
 rtl/param_bus_arbiter_phase_counter.sv | 30 +++
 rtl/param_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_param_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_bus_arbiter_pkg.sv
// Purpose: shared types, select bit indices and helpers for the synth parameter bus arbiter.
// Latency: none (package only).
// Backpressure: none (package only).
package param_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } bus_state_t;

    // Select bit positions, order {com,m2,m1,osc,env}
    localparam int SEL_ENV = 0;
    localparam int SEL_OSC = 1;
    localparam int SEL_M1  = 2;
    localparam int SEL_M2  = 3;
    localparam int SEL_COM = 4;

    // Ceiling log2 with a floor of 1 bit so a counter is never zero-width
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // True when exactly one bit of the (zero-extended) select is set
    function automatic logic sel_is_onehot(input logic [31:0] s);
        return (s != 32'd0) && ((s & (s - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/param_bus_arbiter_phase_counter.sv
// Purpose: down-counter timing one bus phase; reloaded on every phase entry.
// Latency: done is combinational from the count, count updates one cycle after load.
// Backpressure: none; the FSM owns load timing.
import param_bus_arbiter_pkg::*;

module bus_phase_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    // Reload on phase entry, otherwise count down and park at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/param_bus_arbiter.sv
// Purpose: shares the synth parameter bus between the MIDI decoder and the CPU with SETUP/STROBE/HOLD sequencing.
// Latency: request seen in IDLE at cycle 0 -> ack in cycle SETUP_CYC+STROBE_CYC+HOLD_CYC; one IDLE cycle between accesses.
// Backpressure: requesters hold req and fields until ack; losers and locked-out requests simply wait in IDLE.
import param_bus_arbiter_pkg::*;

module param_bus_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int SEL_W      = SEL_COM + 1,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_req,
    input  logic              dec_we,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [SEL_W-1:0]  dec_sel,
    input  logic [DATA_W-1:0] dec_wdata,
    input  logic              dec_lock,
    output logic              dec_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [SEL_W-1:0]  cpu_sel,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              sel_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [SEL_W-1:0]  bus_sel,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_oe,
    output logic              bus_write,
    output logic              bus_read,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_busy,
    output logic              grant_cpu
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC) ?
                             ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                             ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CNT_W = clogb2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    bus_state_t       state;
    bus_req_t         dec_r;
    bus_req_t         cpu_r;
    bus_req_t         win_r;
    logic             win_ok;
    logic             dec_win;
    logic             cpu_win;
    logic             cur_we;
    logic             cur_ok;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;

    // Arbitration: round-robin on a tie, dec_lock reserves the bus for the decoder
    always_comb begin
        dec_r   = {dec_we, dec_addr, dec_sel, dec_wdata};
        cpu_r   = {cpu_we, cpu_addr, cpu_sel, cpu_wdata};
        dec_win = dec_req && (!cpu_req || dec_lock || grant_cpu);
        cpu_win = cpu_req && !dec_lock && (!dec_req || !grant_cpu);
        win_r   = cpu_win ? cpu_r : dec_r;
        win_ok  = sel_is_onehot(32'(win_r.sel));
    end

    // Phase counter reload on entry to SETUP, STROBE and HOLD
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: begin
                if (dec_win || cpu_win) begin
                    cnt_load = 1'b1;
                    cnt_val  = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = STROBE_LD;
                end
            end
            STROBE: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LD;
                end
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    bus_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .cnt      (cnt),
        .done     (cnt_done)
    );

    // Bus sequencing FSM; every bus-facing output is registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_we    <= 1'b0;
            cur_ok    <= 1'b0;
            dec_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            sel_err   <= 1'b0;
            rdata     <= '0;
            bus_addr  <= '0;
            bus_sel   <= '0;
            bus_wdata <= '0;
            bus_oe    <= 1'b0;
            bus_write <= 1'b0;
            bus_read  <= 1'b0;
            bus_busy  <= 1'b0;
            grant_cpu <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (dec_win || cpu_win) begin
                        state     <= SETUP;
                        grant_cpu <= cpu_win;
                        cur_we    <= win_r.we;
                        cur_ok    <= win_ok;
                        bus_addr  <= win_r.addr;
                        bus_sel   <= win_ok ? win_r.sel : '0;
                        bus_wdata <= win_r.wdata;
                        // A bad select never writes, so the data bus is not driven either
                        bus_oe    <= win_r.we & win_ok;
                        bus_busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_done) begin
                        state     <= STROBE;
                        bus_write <= cur_we & cur_ok;
                        bus_read  <= ~cur_we & cur_ok;
                    end
                end
                STROBE: begin
                    if (cnt_done) begin
                        state     <= HOLD;
                        bus_write <= 1'b0;
                        bus_read  <= 1'b0;
                        if (!cur_we && cur_ok) begin
                            rdata <= bus_rdata;
                        end
                        // Single-cycle HOLD: that cycle is already the ack cycle
                        if (HOLD_CYC == 1) begin
                            dec_ack <= ~grant_cpu;
                            cpu_ack <= grant_cpu;
                            sel_err <= ~cur_ok;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_done) begin
                        state     <= IDLE;
                        dec_ack   <= 1'b0;
                        cpu_ack   <= 1'b0;
                        sel_err   <= 1'b0;
                        bus_addr  <= '0;
                        bus_sel   <= '0;
                        bus_wdata <= '0;
                        bus_oe    <= 1'b0;
                        bus_busy  <= 1'b0;
                    end else if (cnt == CNT_W'(1)) begin
                        dec_ack <= ~grant_cpu;
                        cpu_ack <= grant_cpu;
                        sel_err <= ~cur_ok;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_bus_arbiter.sv
// Purpose: directed self-checking bench for param_bus_arbiter with default timing (1/2/1).
// Latency: checks at exact cycle offsets from the IDLE cycle where a request is first seen.
// Backpressure: exercises lock hold-off, round-robin ties and reset mid-transaction.
module tb_param_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_req, dec_we, dec_lock;
    logic [6:0] dec_addr;
    logic [4:0] dec_sel;
    logic [7:0] dec_wdata;
    logic       dec_ack;
    logic       cpu_req, cpu_we;
    logic [6:0] cpu_addr;
    logic [4:0] cpu_sel;
    logic [7:0] cpu_wdata;
    logic       cpu_ack;
    logic [7:0] rdata;
    logic       sel_err;
    logic [6:0] bus_addr;
    logic [4:0] bus_sel;
    logic [7:0] bus_wdata;
    logic       bus_oe, bus_write, bus_read, bus_busy, grant_cpu;
    logic [7:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .dec_req   (dec_req),
        .dec_we    (dec_we),
        .dec_addr  (dec_addr),
        .dec_sel   (dec_sel),
        .dec_wdata (dec_wdata),
        .dec_lock  (dec_lock),
        .dec_ack   (dec_ack),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_sel   (cpu_sel),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .rdata     (rdata),
        .sel_err   (sel_err),
        .bus_addr  (bus_addr),
        .bus_sel   (bus_sel),
        .bus_wdata (bus_wdata),
        .bus_oe    (bus_oe),
        .bus_write (bus_write),
        .bus_read  (bus_read),
        .bus_rdata (bus_rdata),
        .bus_busy  (bus_busy),
        .grant_cpu (grant_cpu)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called in the IDLE cycle where the request is first visible; returns in the ack cycle
    task automatic run_txn(input string tag, input logic exp_cpu, input logic [6:0] exp_addr);
        chk({tag, "_idle_busy"}, 32'(bus_busy), 0);
        cyc();
        chk({tag, "_grant"}, 32'(grant_cpu), 32'(exp_cpu));
        chk({tag, "_addr"}, 32'(bus_addr), 32'(exp_addr));
        chk({tag, "_busy"}, 32'(bus_busy), 1);
        cyc();
        cyc();
        cyc();
        chk({tag, "_dec_ack"}, 32'(dec_ack), 32'(!exp_cpu));
        chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'(exp_cpu));
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        reset     = 1'b1;
        dec_req   = 1'b0; dec_we = 1'b0; dec_lock = 1'b0;
        dec_addr  = '0;   dec_sel = '0;  dec_wdata = '0;
        cpu_req   = 1'b0; cpu_we = 1'b0;
        cpu_addr  = '0;   cpu_sel = '0;  cpu_wdata = '0;
        bus_rdata = 8'h00;

        // Reset state
        #7;
        chk("rst_busy",  32'(bus_busy),  0);
        chk("rst_grant", 32'(grant_cpu), 1);
        chk("rst_dack",  32'(dec_ack),   0);
        chk("rst_cack",  32'(cpu_ack),   0);
        chk("rst_rdata", 32'(rdata),     0);
        chk("rst_sel",   32'(bus_sel),   0);
        chk("rst_write", 32'(bus_write), 0);
        #5 reset = 1'b0;
        cyc();

        // Simultaneous requests after reset: dec first, then alternate
        dec_we = 1'b1; dec_addr = 7'h11; dec_sel = 5'b00001; dec_wdata = 8'h11;
        cpu_we = 1'b1; cpu_addr = 7'h22; cpu_sel = 5'b00100; cpu_wdata = 8'h22;
        dec_req = 1'b1; cpu_req = 1'b1;
        run_txn("t3_dec1", 1'b0, 7'h11);
        cyc();
        run_txn("t3_cpu1", 1'b1, 7'h22);
        cyc();
        run_txn("t3_dec2", 1'b0, 7'h11);
        dec_req = 1'b0;
        cyc();
        run_txn("t3_cpu2", 1'b1, 7'h22);
        cpu_req = 1'b0;
        cyc();

        // Decoder write, cycle-accurate phases
        dec_we = 1'b1; dec_addr = 7'h12; dec_sel = 5'b00010; dec_wdata = 8'hA5;
        dec_req = 1'b1;
        cyc();
        chk("t1_c1_write", 32'(bus_write), 0);
        chk("t1_c1_oe",    32'(bus_oe),    1);
        chk("t1_c1_sel",   32'(bus_sel),   5'b00010);
        chk("t1_c1_grant", 32'(grant_cpu), 0);
        cyc();
        chk("t1_c2_write", 32'(bus_write), 1);
        cyc();
        chk("t1_c3_write", 32'(bus_write), 1);
        chk("t1_c3_ack",   32'(dec_ack),   0);
        cyc();
        chk("t1_c4_write", 32'(bus_write), 0);
        chk("t1_c4_ack",   32'(dec_ack),   1);
        chk("t1_c4_selerr",32'(sel_err),   0);
        chk("t1_c4_wdata", 32'(bus_wdata), 8'hA5);
        dec_req = 1'b0;
        cyc();
        chk("t1_c5_ack",   32'(dec_ack),   0);
        chk("t1_c5_busy",  32'(bus_busy),  0);
        chk("t1_c5_sel",   32'(bus_sel),   0);
        chk("t1_c5_oe",    32'(bus_oe),    0);

        // CPU read with capture
        cpu_we = 1'b0; cpu_addr = 7'h02; cpu_sel = 5'b10000; bus_rdata = 8'h3C;
        cpu_req = 1'b1;
        cyc();
        chk("t2_c1_grant", 32'(grant_cpu), 1);
        chk("t2_c1_oe",    32'(bus_oe),    0);
        chk("t2_c1_read",  32'(bus_read),  0);
        cyc();
        chk("t2_c2_read",  32'(bus_read),  1);
        chk("t2_c2_write", 32'(bus_write), 0);
        cyc();
        chk("t2_c3_read",  32'(bus_read),  1);
        cyc();
        chk("t2_c4_ack",   32'(cpu_ack),   1);
        chk("t2_c4_rdata", 32'(rdata),     8'h3C);
        chk("t2_c4_read",  32'(bus_read),  0);
        chk("t2_c4_dack",  32'(dec_ack),   0);
        cpu_req = 1'b0;
        cyc();
        chk("t2_c5_ack",   32'(cpu_ack),   0);

        // Lock: in-flight CPU completes, then decoder burst holds the bus
        cpu_we = 1'b1; cpu_addr = 7'h33; cpu_sel = 5'b01000; cpu_wdata = 8'h5A;
        cpu_req = 1'b1;
        cyc();
        chk("t4_c1_grant", 32'(grant_cpu), 1);
        cyc();
        dec_lock = 1'b1;
        dec_we = 1'b1; dec_addr = 7'h40; dec_sel = 5'b00001; dec_wdata = 8'h01;
        dec_req = 1'b1;
        cyc();
        cyc();
        chk("t4_inflight_cack", 32'(cpu_ack), 1);
        chk("t4_inflight_dack", 32'(dec_ack), 0);
        cpu_addr = 7'h34;
        cyc();
        run_txn("t4_burst1", 1'b0, 7'h40);
        dec_addr = 7'h41;
        cyc();
        run_txn("t4_burst2", 1'b0, 7'h41);
        dec_addr = 7'h42;
        cyc();
        run_txn("t4_burst3", 1'b0, 7'h42);
        dec_req = 1'b0;
        cyc();
        chk("t4_locked_busy0", 32'(bus_busy), 0);
        cyc();
        chk("t4_locked_busy1", 32'(bus_busy), 0);
        chk("t4_locked_cack",  32'(cpu_ack),  0);
        dec_lock = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (cpu_ack) begin
                n = i + 1;
                break;
            end
        end
        chk("t4_unlock_latency", 32'(n), 4);
        chk("t4_unlock_addr", 32'(bus_addr), 7'h34);
        cpu_req = 1'b0;
        cyc();

        // Multi-hot select: no strobe, sel_err with ack, rdata kept
        cpu_we = 1'b1; cpu_addr = 7'h05; cpu_sel = 5'b00011; cpu_wdata = 8'hFF;
        cpu_req = 1'b1;
        cyc();
        chk("t6_c1_sel",   32'(bus_sel),   0);
        cyc();
        chk("t6_c2_write", 32'(bus_write), 0);
        cyc();
        chk("t6_c3_write", 32'(bus_write), 0);
        cyc();
        chk("t6_c4_ack",   32'(cpu_ack),   1);
        chk("t6_c4_selerr",32'(sel_err),   1);
        chk("t6_c4_rdata", 32'(rdata),     8'h3C);
        cpu_req = 1'b0;
        cyc();
        chk("t6_c5_selerr",32'(sel_err),   0);

        // Zero select read: no strobe, rdata not captured
        cpu_we = 1'b0; cpu_sel = 5'b00000; bus_rdata = 8'h77;
        cpu_req = 1'b1;
        cyc();
        cyc();
        chk("t6z_c2_read",  32'(bus_read), 0);
        cyc();
        cyc();
        chk("t6z_c4_ack",   32'(cpu_ack),  1);
        chk("t6z_c4_selerr",32'(sel_err),  1);
        chk("t6z_c4_rdata", 32'(rdata),    8'h3C);
        cpu_req = 1'b0;
        bus_rdata = 8'h3C;
        cyc();

        // Reset in STROBE: async clear, no ack, then a fresh request works
        dec_we = 1'b1; dec_addr = 7'h44; dec_sel = 5'b00001; dec_wdata = 8'h44;
        dec_req = 1'b1;
        cyc();
        cyc();
        chk("t5_strobe_write", 32'(bus_write), 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_write", 32'(bus_write), 0);
        chk("t5_rst_sel",   32'(bus_sel),   0);
        chk("t5_rst_busy",  32'(bus_busy),  0);
        chk("t5_rst_grant", 32'(grant_cpu), 1);
        dec_req = 1'b0;
        cyc();
        chk("t5_rst_dack",  32'(dec_ack),   0);
        #2 reset = 1'b0;
        cyc();
        chk("t5_post_busy", 32'(bus_busy),  0);
        chk("t5_post_dack", 32'(dec_ack),   0);
        dec_addr = 7'h45;
        dec_req = 1'b1;
        run_txn("t5_retry", 1'b0, 7'h45);
        dec_req = 1'b0;
        cyc();
        chk("t5_end_busy", 32'(bus_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
